hex_keypad_scanner: RTL and testbench

- Input-side counterpart to the multiplexed four-digit seven-segment driver.
- Scans a 4×4 hex keypad matrix:
  - drives one column low at a time, at the same 2^N-cycle cadence the display uses per digit;
  - samples the active-low rows;
  - debounces press and release;
  - delivers one 4-bit key code per press over a valid/ready handshake.
- Sits between the board keypad pins and the user-input/control logic.

---
 rtl/hex_keypad_scanner.sv | 177 +++++++++++++++++
 tb/tb_hex_keypad_scanner.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: column scan, row sync, press/release debounce, valid/ready key output.
// Define KEYPAD_OVERRUN_EN to add the sticky key_overrun flag for keys dropped while key_valid is pending.
module hex_keypad_scanner #(
  parameter int unsigned SCAN_DIV_BITS  = 15,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready
`ifdef KEYPAD_OVERRUN_EN
  ,
  output logic       key_overrun
`endif
);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;

  localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);

  logic [3:0]               row_meta_q, row_s_q;
  logic [SCAN_DIV_BITS-1:0] presc_q;
  logic                     tick;
  logic [1:0]               col_q, col_d;
  logic [1:0]               state_q, state_d;
  logic [3:0]               cnt_q, cnt_d, cnt_inc;
  logic [3:0]               cand_q, cand_d;
  logic [3:0]               code_q, code_d;
  logic                     valid_q, valid_d;
  logic                     hit;
  logic [1:0]               row_idx;
  logic                     deliver;
  logic [3:0]               deliver_code;
  logic                     accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta_q <= '1;
      row_s_q    <= '1;
      presc_q    <= '0;
    end else begin
      row_meta_q <= key_row;
      row_s_q    <= row_meta_q;
      presc_q    <= presc_q + SCAN_DIV_BITS'(1);
    end
  end

  assign tick    = &presc_q;
  assign key_col = reset ? 4'b1111 : ~(4'b0001 << col_q);
  assign hit     = ~&row_s_q;
  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    row_idx = 2'd0;
    if (!row_s_q[0])      row_idx = 2'd0;
    else if (!row_s_q[1]) row_idx = 2'd1;
    else if (!row_s_q[2]) row_idx = 2'd2;
    else if (!row_s_q[3]) row_idx = 2'd3;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cand_d       = cand_q;
    col_d        = col_q;
    deliver      = 1'b0;
    deliver_code = cand_q;
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (hit) begin
            cand_d = {row_idx, col_q};
            // A single-sample debounce delivers at the detecting tick itself.
            if (DS == 4'd1) begin
              deliver      = 1'b1;
              deliver_code = {row_idx, col_q};
              state_d      = ST_HELD;
              cnt_d        = '0;
            end else begin
              cnt_d   = 4'd1;
              state_d = ST_DEBOUNCE;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (hit && row_idx == cand_q[3:2]) begin
            if (cnt_inc == DS) begin
              deliver = 1'b1;
              state_d = ST_HELD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = ST_SCAN;
            col_d   = col_q + 2'd1;
          end
        end
        ST_HELD: begin
          if (hit) begin
            cnt_d = '0;
          end else if (cnt_inc == DS) begin
            state_d = ST_SCAN;
            col_d   = col_q + 2'd1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_SCAN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign accept = valid_q && key_ready;

  always_comb begin
    valid_d = valid_q && !accept;
    code_d  = code_q;
    if (deliver && (!valid_q || key_ready)) begin
      valid_d = 1'b1;
      code_d  = deliver_code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_SCAN;
      cnt_q   <= '0;
      cand_q  <= '0;
      col_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      col_q   <= col_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;

`ifdef KEYPAD_OVERRUN_EN
  logic overrun_q, overrun_d;
  logic drop;

  assign drop = deliver && valid_q && !key_ready;

  always_comb begin
    overrun_d = overrun_q;
    if (drop)        overrun_d = 1'b1;
    else if (accept) overrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) overrun_q <= 1'b0;
    else       overrun_q <= overrun_d;
  end

  assign key_overrun = overrun_q;
`endif

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Bench for hex_keypad_scanner: keypad matrix model, directed scenarios, randomized presses vs. a tick-level reference.
module tb_hex_keypad_scanner;

  localparam int unsigned SDB   = 2;
  localparam int unsigned DS    = 3;
  localparam int          DWELL = 4;

  localparam int IDLE    = 0;
  localparam int CONFIRM = 1;
  localparam int HOLD    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_ready;
  logic [3:0]  key_row, key_col, key_code;
  logic        key_valid;
  logic [15:0] pressed;
`ifdef KEYPAD_OVERRUN_EN
  logic        key_overrun;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hex_keypad_scanner #(
    .SCAN_DIV_BITS (SDB),
    .DEBOUNCE_SCANS(DS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_row  (key_row),
    .key_col  (key_col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready)
`ifdef KEYPAD_OVERRUN_EN
    ,
    .key_overrun(key_overrun)
`endif
  );

  // Physical matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    key_row = 4'hF;
    for (int k = 0; k < 16; k++)
      if (pressed[k] && !key_col[k % 4]) key_row[k / 4] = 1'b0;
  end

  task automatic check(input string tag, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model, advanced once per clock, in the bench's own terms.
  logic [3:0] m_s1, m_s2;
  int         m_presc, m_col, m_mode, m_cand, m_agree, m_rel, m_code;
  bit         m_valid, m_ovr;

  function automatic logic [3:0] matrix_rows(input logic [15:0] p, input int col);
    logic [3:0] rows = 4'hF;
    for (int r = 0; r < 4; r++)
      if (p[r * 4 + col]) rows[r] = 1'b0;
    return rows;
  endfunction

  task automatic model_reset();
    m_s1 = 4'hF; m_s2 = 4'hF;
    m_presc = 0; m_col = 0; m_mode = IDLE;
    m_cand = 0; m_agree = 0; m_rel = 0;
    m_valid = 0; m_code = 0; m_ovr = 0;
  endtask

  task automatic model_step(input bit rdy, input logic [15:0] p);
    logic [3:0] phys;
    bit tick, hit, deliver, drop, hs;
    int row;
    phys    = matrix_rows(p, m_col);
    tick    = (m_presc == DWELL - 1);
    hit     = (m_s2 != 4'hF);
    row     = 0;
    for (int r = 3; r >= 0; r--)
      if (!m_s2[r]) row = r;
    deliver = 0;
    if (tick) begin
      if (m_mode == IDLE) begin
        if (hit) begin
          m_cand  = row * 4 + m_col;
          m_agree = 1;
          if (m_agree == DS) begin deliver = 1; m_mode = HOLD; m_rel = 0; end
          else m_mode = CONFIRM;
        end else m_col = (m_col + 1) % 4;
      end else if (m_mode == CONFIRM) begin
        if (hit && row == m_cand / 4) begin
          m_agree++;
          if (m_agree == DS) begin deliver = 1; m_mode = HOLD; m_rel = 0; end
        end else begin
          m_mode = IDLE;
          m_col  = (m_col + 1) % 4;
        end
      end else begin
        if (hit) m_rel = 0;
        else begin
          m_rel++;
          if (m_rel == DS) begin m_mode = IDLE; m_rel = 0; m_col = (m_col + 1) % 4; end
        end
      end
    end
    hs   = m_valid && rdy;
    drop = deliver && m_valid && !rdy;
    if (hs) m_valid = 0;
    if (deliver && !drop) begin m_valid = 1; m_code = m_cand; end
    if (drop) m_ovr = 1;
    else if (hs) m_ovr = 0;
    m_s2    = m_s1;
    m_s1    = phys;
    m_presc = (m_presc + 1) % DWELL;
  endtask

  // One clock: apply inputs, compare every output with the model, then advance the model.
  task automatic step(input bit r, input bit rdy, input logic [15:0] p);
    logic [3:0] ec;
    @(negedge clk);
    reset = r; key_ready = rdy; pressed = p;
    #1;
    ec = 4'hF;
    if (!r) ec[m_col] = 1'b0;
    check("key_col", key_col, ec);
    check("key_valid", key_valid, m_valid);
    check("key_code", key_code, 4'(m_code));
`ifdef KEYPAD_OVERRUN_EN
    check("key_overrun", key_overrun, m_ovr);
`endif
    if (r) model_reset();
    else   model_step(rdy, p);
  endtask

  task automatic reset_dut();
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
  endtask

  function automatic logic [15:0] key(input int r, input int c);
    logic [15:0] v = '0;
    v[r * 4 + c] = 1'b1;
    return v;
  endfunction

  logic [3:0] idle_seq [5] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};

  initial begin
    reset = 1'b1; key_ready = 1'b0; pressed = '0;
    model_reset();
    reset_dut();

    // Idle scan
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 1'b0, '0);
      check("idle_col", key_col, idle_seq[c / 4]);
      check("idle_valid", key_valid, 4'd0);
    end

    // Single press (2,1), handshake at 20, release at 24
    reset_dut();
    for (int c = 0; c < 45; c++) begin
      step(1'b0, c == 20, (c < 24) ? key(2, 1) : '0);
      if (c == 15) check("press_pre", key_valid, 4'd0);
      if (c == 16) begin
        check("press_valid", key_valid, 4'd1);
        check("press_code", key_code, 4'h9);
      end
      if (c == 20) check("hold_valid", key_valid, 4'd1);
      if (c == 21) check("hs_clear", key_valid, 4'd0);
      if (c >= 4 && c <= 35) check("frozen_col", key_col, 4'b1101);
      if (c == 36) check("resume_col", key_col, 4'b1011);
      if (c == 44) check("no_second", key_valid, 4'd0);
    end

    // Bounce rejection on (0,3)
    reset_dut();
    for (int c = 0; c < 32; c++) begin
      step(1'b0, 1'b0, (c >= 10 && c < 20) ? key(0, 3) : '0);
      if (c == 23) check("bounce_hold", key_col, 4'b0111);
      if (c == 24) check("bounce_col0", key_col, 4'b1110);
      if (c == 31) check("bounce_valid", key_valid, 4'd0);
    end

    // Overrun: 5 then A with key_ready low
    reset_dut();
    for (int c = 0; c < 170; c++) begin
      step(1'b0, c == 160, (c < 40) ? key(1, 1) : (c >= 80 && c < 120) ? key(2, 2) : '0);
      if (c == 159) begin
        check("ovr_code", key_code, 4'h5);
        check("ovr_valid", key_valid, 4'd1);
`ifdef KEYPAD_OVERRUN_EN
        check("ovr_flag", key_overrun, 4'd1);
`endif
      end
      if (c == 161) begin
        check("ovr_hs_valid", key_valid, 4'd0);
`ifdef KEYPAD_OVERRUN_EN
        check("ovr_hs_flag", key_overrun, 4'd0);
`endif
      end
    end

    // Reset while debouncing (2,1)
    reset_dut();
    for (int c = 0; c < 12; c++) step(1'b0, 1'b0, key(2, 1));
    step(1'b1, 1'b0, key(2, 1));
    check("rst_col", key_col, 4'hF);
    step(1'b1, 1'b0, key(2, 1));
    check("rst_valid", key_valid, 4'd0);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b0, key(2, 1));
      if (c == 0) check("rst_col0", key_col, 4'b1110);
    end

    // Randomized presses, multi-key rollover, bounces, ready and rare resets
    reset_dut();
    for (int seg = 0; seg < 40; seg++) begin
      logic [15:0] p;
      int kind, hold, gap;
      kind = $urandom_range(0, 9);
      p    = key($urandom_range(0, 3), $urandom_range(0, 3));
      if (kind >= 6 && kind <= 7) p = p | key($urandom_range(0, 3), $urandom_range(0, 3));
      if (kind == 8) p = '0;
      hold = (kind == 9) ? $urandom_range(1, 8) : $urandom_range(10, 60);
      gap  = $urandom_range(0, 40);
      for (int c = 0; c < hold + gap; c++)
        step($urandom_range(0, 399) == 0, $urandom_range(0, 3) == 0, (c < hold) ? p : '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
